// File: rtl/slip_rx_decoder.sv
// SLIP (RFC 1055) receive decoder: strips END/ESC framing and tags frame ends with last/error.
// Optional frame/error statistics counters are enabled by defining SLIP_STATS_EN.
module slip_rx_decoder #(
    parameter int MaxLen    = 256,
    parameter bit DropEmpty = 1'b1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  logic [7:0] s_data_i,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic [7:0] m_data_o,
    output logic       m_last_o,
    output logic       m_error_o
`ifdef SLIP_STATS_EN
    ,
    output logic [15:0] frame_count_o,
    output logic [15:0] error_count_o
`endif
);

    localparam int LenW = $clog2(MaxLen + 1);

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    localparam logic [1:0] ST_NORMAL  = 2'b00;
    localparam logic [1:0] ST_ESCAPE  = 2'b01;
    localparam logic [1:0] ST_DISCARD = 2'b10;

    logic [1:0]      r_state;
    logic [7:0]      r_hold_data;
    logic            r_hold_vld;
    logic [LenW-1:0] r_len;
    logic            r_m_valid;
    logic [7:0]      r_m_data;
    logic            r_m_last;
    logic            r_m_error;

    logic            w_accept;
    logic            w_end_has_frame;
    logic [1:0]      w_state_next;
    logic [7:0]      w_hold_data_next;
    logic            w_hold_vld_next;
    logic [LenW-1:0] w_len_next;
    logic            w_is_data;
    logic [7:0]      w_data_byte;
    logic            w_err_term;
    logic            w_emit;
    logic            w_emit_last;
    logic            w_emit_error;

    assign s_ready_o = !r_m_valid || m_ready_i;
    assign w_accept  = s_valid_i && s_ready_o;

    // A zero-byte frame has no beat to carry it, so DropEmpty cannot alter the result.
    assign w_end_has_frame = r_hold_vld & (DropEmpty | r_hold_vld);

    always_comb begin
        w_state_next     = r_state;
        w_hold_data_next = r_hold_data;
        w_hold_vld_next  = r_hold_vld;
        w_len_next       = r_len;
        w_is_data        = 1'b0;
        w_data_byte      = s_data_i;
        w_err_term       = 1'b0;
        w_emit           = 1'b0;
        w_emit_last      = 1'b0;
        w_emit_error     = 1'b0;

        if (w_accept) begin
            case (r_state)
                ST_NORMAL: begin
                    if (s_data_i == SLIP_END) begin
                        w_emit          = w_end_has_frame;
                        w_emit_last     = 1'b1;
                        w_hold_vld_next = 1'b0;
                        w_len_next      = '0;
                    end else if (s_data_i == SLIP_ESC) begin
                        w_state_next = ST_ESCAPE;
                    end else begin
                        w_is_data = 1'b1;
                    end
                end
                ST_ESCAPE: begin
                    w_state_next = ST_NORMAL;
                    if (s_data_i == SLIP_ESC_END) begin
                        w_is_data   = 1'b1;
                        w_data_byte = SLIP_END;
                    end else if (s_data_i == SLIP_ESC_ESC) begin
                        w_is_data   = 1'b1;
                        w_data_byte = SLIP_ESC;
                    end else if (s_data_i == SLIP_END) begin
                        w_err_term = 1'b1;
                    end else begin
                        w_err_term   = 1'b1;
                        w_state_next = ST_DISCARD;
                    end
                end
                default: begin
                    if (s_data_i == SLIP_END) begin
                        w_state_next    = ST_NORMAL;
                        w_hold_vld_next = 1'b0;
                        w_len_next      = '0;
                    end
                end
            endcase

            // Overflow is detected on the byte that would exceed the limit, so a
            // frame of exactly MaxLen bytes still closes cleanly on END.
            if (w_is_data) begin
                if (r_len == LenW'(MaxLen)) begin
                    w_err_term   = 1'b1;
                    w_state_next = ST_DISCARD;
                end else begin
                    w_emit           = r_hold_vld;
                    w_hold_data_next = w_data_byte;
                    w_hold_vld_next  = 1'b1;
                    w_len_next       = r_len + LenW'(1);
                end
            end

            if (w_err_term) begin
                w_emit          = r_hold_vld;
                w_emit_last     = 1'b1;
                w_emit_error    = 1'b1;
                w_hold_vld_next = 1'b0;
                w_len_next      = '0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= ST_NORMAL;
            r_hold_data <= 8'h00;
            r_hold_vld  <= 1'b0;
            r_len       <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= 8'h00;
            r_m_last    <= 1'b0;
            r_m_error   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hold_data <= w_hold_data_next;
            r_hold_vld  <= w_hold_vld_next;
            r_len       <= w_len_next;
            if (w_emit) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_hold_data;
                r_m_last  <= w_emit_last;
                r_m_error <= w_emit_error;
            end else if (m_ready_i) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_m_data;
    assign m_last_o  = r_m_last;
    assign m_error_o = r_m_error;

`ifdef SLIP_STATS_EN
    logic [15:0] r_frame_count;
    logic [15:0] r_error_count;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_frame_count <= 16'h0000;
            r_error_count <= 16'h0000;
        end else begin
            if (r_m_valid && m_ready_i && r_m_last && !r_m_error && r_frame_count != 16'hFFFF) begin
                r_frame_count <= r_frame_count + 16'h0001;
            end
            if (w_err_term && r_error_count != 16'hFFFF) begin
                r_error_count <= r_error_count + 16'h0001;
            end
        end
    end

    assign frame_count_o = r_frame_count;
    assign error_count_o = r_error_count;
`endif

endmodule

// File: tb/tb_slip_rx_decoder.sv
// Scoreboard bench for slip_rx_decoder: a frame-level SLIP reference model feeds an expect queue
// that an independent output monitor drains.
module tb_slip_rx_decoder;

    localparam int MAXLEN = 4;
    localparam logic [7:0] C_END = 8'hC0;
    localparam logic [7:0] C_ESC = 8'hDB;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       s_valid_i = 1'b0;
    logic       s_ready_o;
    logic [7:0] s_data_i = 8'h00;
    logic       m_valid_o;
    logic       m_ready_i = 1'b1;
    logic [7:0] m_data_o;
    logic       m_last_o;
    logic       m_error_o;
`ifdef SLIP_STATS_EN
    logic [15:0] frame_count_o;
    logic [15:0] error_count_o;
`endif

    always #5 clock_i = ~clock_i;

    slip_rx_decoder #(.MaxLen(MAXLEN), .DropEmpty(1'b1)) dut (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_last_o  (m_last_o),
        .m_error_o (m_error_o)
`ifdef SLIP_STATS_EN
        ,
        .frame_count_o (frame_count_o),
        .error_count_o (error_count_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int stalls   = 0;
    int model_frames = 0;
    int model_errors = 0;
    bit rand_ready = 1'b0;

    logic [9:0] exp_q[$];   // {data, last, error}
    logic [7:0] seg[$];     // raw bytes seen since the last END

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Decode one END-delimited segment from first principles.
    task automatic model_frame();
        logic [7:0] payload[$];
        bit err = 1'b0;
        int i = 0;
        while (i < seg.size() && !err) begin
            logic [7:0] v;
            bit got = 1'b0;
            if (seg[i] == C_ESC) begin
                if (i + 1 >= seg.size()) err = 1'b1;
                else if (seg[i+1] == 8'hDC) begin v = 8'hC0; got = 1'b1; end
                else if (seg[i+1] == 8'hDD) begin v = 8'hDB; got = 1'b1; end
                else err = 1'b1;
                i += 2;
            end else begin
                v = seg[i];
                got = 1'b1;
                i += 1;
            end
            if (got) begin
                if (payload.size() == MAXLEN) err = 1'b1;
                else payload.push_back(v);
            end
        end
        for (int k = 0; k < payload.size(); k++) begin
            bit lst = (k == payload.size() - 1);
            exp_q.push_back({payload[k], lst, lst & err});
        end
        if (err) model_errors++;
        else if (payload.size() != 0) model_frames++;
    endtask

    task automatic model_stream(input logic [7:0] q[$]);
        foreach (q[k]) begin
            if (q[k] == C_END) begin
                model_frame();
                seg.delete();
            end else begin
                seg.push_back(q[k]);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        int guard = 0;
        s_valid_i = 1'b1;
        s_data_i  = b;
        do begin
            @(negedge clock_i);
            ok = s_ready_o;
            if (!ok) stalls++;
            @(posedge clock_i);
            #1;
            guard++;
            if (guard > 1000) begin
                $display("FAIL send_timeout: s_ready_o stuck at %0b required 1", s_ready_o);
                $fatal(1, "input stalled");
            end
        end while (!ok);
        s_valid_i = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] q[$]);
        model_stream(q);
        foreach (q[k]) begin
            send_byte(q[k]);
            if (rand_ready && $urandom_range(0, 7) == 0) begin
                @(posedge clock_i);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(posedge clock_i);
            cyc++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(posedge clock_i);
        #1;
    endtask

    always begin
        @(posedge clock_i);
        #1;
        m_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Output monitor: scoreboard pop plus stall-stability check.
    bit         prev_stall = 1'b0;
    logic [10:0] prev_out;
    always @(negedge clock_i) begin
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {m_valid_o, m_data_o, m_last_o, m_error_o}, prev_out);
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data=%0h last=%0b err=%0b required none",
                             m_data_o, m_last_o, m_error_o);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("beat", {m_data_o, m_last_o, m_error_o}, e);
                    $display("beat data=%02h last=%0b err=%0b", m_data_o, m_last_o, m_error_o);
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_out   = {m_valid_o, m_data_o, m_last_o, m_error_o};
        end
    end

    initial begin
        logic [7:0] q[$];
        repeat (3) @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        check("reset_m_valid", m_valid_o, 0);
        check("reset_m_data", m_data_o, 0);
        check("reset_m_last", m_last_o, 0);
        check("reset_s_ready", s_ready_o, 1);

        q = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0};
        stalls = 0;
        send_stream(q);
        check("t1_no_stall", stalls, 0);
        q = '{8'h11, 8'hDB, 8'hDC, 8'h22, 8'hDB, 8'hDD, 8'hC0};
        send_stream(q);
        q = '{8'h05, 8'hDB, 8'h41, 8'h06, 8'h07, 8'hC0, 8'h08, 8'hC0};
        send_stream(q);
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0};
        send_stream(q);
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hC0};
        send_stream(q);
        q = '{8'hDB, 8'hC0, 8'hC0, 8'hC0, 8'h33, 8'hDB, 8'hC0};
        send_stream(q);
        drain("directed_drain");

        rand_ready = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int n;
            q.delete();
            if ($urandom_range(0, 4) == 0) q.push_back(C_END);
            n = $urandom_range(0, 7);
            for (int k = 0; k < n; k++) begin
                int r = $urandom_range(0, 19);
                if (r == 0) begin q.push_back(C_ESC); q.push_back(8'hDC); end
                else if (r == 1) begin q.push_back(C_ESC); q.push_back(8'hDD); end
                else if (r == 2) begin
                    logic [7:0] bad;
                    do bad = 8'($urandom_range(0, 255)); while (bad == 8'hDC || bad == 8'hDD);
                    q.push_back(C_ESC);
                    q.push_back(bad);
                end else if (r == 3) q.push_back(C_ESC);
                else q.push_back(8'($urandom_range(0, 255)));
            end
            q.push_back(C_END);
            send_stream(q);
        end
        rand_ready = 1'b0;
        drain("random_drain");
`ifdef SLIP_STATS_EN
        check("frame_count", frame_count_o, model_frames);
        check("error_count", error_count_o, model_errors);
`endif

        // Reset with one byte emitted and a second byte held.
        exp_q.push_back({8'hAA, 1'b0, 1'b0});
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clock_i);
        #1;
        reset_i = 1'b1;
        @(posedge clock_i);
        #1;
        check("rst_mid_m_valid", m_valid_o, 0);
        check("rst_mid_m_data", m_data_o, 0);
        check("rst_mid_m_last", m_last_o, 0);
        check("rst_mid_m_error", m_error_o, 0);
        reset_i = 1'b0;
        seg.delete();
        model_frames = 0;
        model_errors = 0;
        check("rst_scoreboard_empty", exp_q.size(), 0);
        q = '{8'hCC, 8'hC0};
        send_stream(q);
        drain("reset_drain");
`ifdef SLIP_STATS_EN
        check("frame_count_after_reset", frame_count_o, model_frames);
        check("error_count_after_reset", error_count_o, model_errors);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
